// File: rtl/norm_pack.sv
// norm_pack: normalizes, rounds and packs a post-add floating-point sum word
// into an IEEE-754 single-precision result.
// Input word: [36] sign, [35:28] exponent, [27:0] mantissa, where the mantissa
// is {carry, hidden, fraction[22:0], guard, round, sticky}.
// Optional feature macro: FPADD_ROUND_EN. When it is defined, the block rounds
// to nearest even. When it is undefined, guard/round/sticky are discarded.
module norm_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [36:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_r;
    logic        sign_r;
    logic [8:0]  e_r;
    logic [27:0] m_r;
    logic        zero_r;
    logic        den_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [31:0] result_r;
    logic        ovf_r;

    logic        inc_s;
    logic [24:0] sum_s;
    logic [8:0]  exp_s;
    logic [31:0] pack_s;
    logic        ovf_s;

    // Rounding decision, then the packed value built from the normalized registers
    always_comb begin
        inc_s  = 1'b0;
        sum_s  = 25'd0;
        exp_s  = 9'd0;
        pack_s = 32'd0;
        ovf_s  = 1'b0;
`ifdef FPADD_ROUND_EN
        inc_s = m_r[2] & (m_r[1] | m_r[0] | m_r[3]);
`else
        inc_s = 1'b0;
`endif
        // 24-bit significand {hidden, fraction} plus one bit of rounding carry room
        sum_s = {1'b0, m_r[26:3]} + {24'd0, inc_s};
        if (den_r) begin
            // A denormal that rounds up into the hidden bit becomes the smallest normal
            exp_s = {8'd0, sum_s[23]};
        end else begin
            exp_s = e_r + {8'd0, sum_s[24]};
        end
        if (zero_r) begin
            pack_s = {sign_r, 31'd0};
            ovf_s  = 1'b0;
        end else if (exp_s >= 9'd255) begin
            pack_s = {sign_r, 8'hFF, 23'd0};
            ovf_s  = 1'b1;
        end else begin
            // On a rounding carry out of the fraction, sum_s[22:0] is already zero
            pack_s = {sign_r, exp_s[7:0], sum_s[22:0]};
            ovf_s  = 1'b0;
        end
    end

    // Control FSM: accept, normalize one bit per cycle, round/pack, hold for downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sign_r      <= 1'b0;
            e_r         <= 9'd0;
            m_r         <= 28'd0;
            zero_r      <= 1'b0;
            den_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= 32'd0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sign_r     <= in_word[36];
                        e_r        <= {1'b0, in_word[35:28]};
                        m_r        <= in_word[27:0];
                        zero_r     <= 1'b0;
                        den_r      <= 1'b0;
                        in_ready_r <= 1'b0;
                        state_r    <= NORM;
                    end
                end
                NORM: begin
                    if (m_r[27]) begin
                        // The bit shifted out is folded into the sticky bit
                        m_r     <= {1'b0, m_r[27:2], m_r[1] | m_r[0]};
                        e_r     <= e_r + 9'd1;
                        state_r <= ROUND;
                    end else if (m_r == 28'd0) begin
                        zero_r  <= 1'b1;
                        state_r <= ROUND;
                    end else if (m_r[26]) begin
                        state_r <= ROUND;
                    end else if (e_r <= 9'd1) begin
                        // The exponent floor has been reached, so the value stays denormal
                        den_r   <= 1'b1;
                        state_r <= ROUND;
                    end else begin
                        m_r     <= {m_r[26:0], 1'b0};
                        e_r     <= e_r - 9'd1;
                        state_r <= NORM;
                    end
                end
                ROUND: begin
                    result_r    <= pack_s;
                    ovf_r       <= ovf_s;
                    out_valid_r <= 1'b1;
                    state_r     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_norm_pack.sv
// Self-checking bench for norm_pack: directed corner cases followed by random
// words checked against an arithmetic reference model.
module tb_norm_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [36:0] in_word = 37'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf;

    int vectors = 0;
    int miscompares = 0;

    norm_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf)
    );

    // 10-time-unit clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: normalize with integer arithmetic, round, and pack.
    function automatic void model(input logic [36:0] w, output logic [31:0] r,
                                  output logic o, output int k);
        longint m;
        longint mant;
        int     e;
        int     ex;
        logic   s;
        logic   zero;
        logic   den;
        logic [7:0]  exb;
        logic [22:0] frb;
        s = w[36];
        e = int'(w[35:28]);
        m = longint'(w[27:0]);
        k = 0;
        zero = 1'b0;
        den = 1'b0;
        if (m >= 64'h8000000) begin
            m = (m >> 1) | (m & 64'd1);
            e = e + 1;
        end else if (m == 0) begin
            zero = 1'b1;
        end else begin
            while (m < 64'h4000000 && e > 1) begin
                m = m * 2;
                e = e - 1;
                k = k + 1;
            end
            den = (m < 64'h4000000);
        end
        mant = m >> 3;
`ifdef FPADD_ROUND_EN
        if (((m >> 2) & 1) == 1 && ((m & 3) != 0 || (mant & 1) == 1))
            mant = mant + 1;
`endif
        o = 1'b0;
        if (zero) begin
            r = {s, 31'd0};
        end else begin
            if (den) begin
                ex = (mant >= 64'h800000) ? 1 : 0;
            end else begin
                if (mant >= 64'h1000000) begin
                    mant = mant >> 1;
                    e = e + 1;
                end
                ex = e;
            end
            if (ex >= 255) begin
                r = {s, 8'hFF, 23'd0};
                o = 1'b1;
            end else begin
                exb = 8'(ex);
                frb = 23'(mant);
                r = {s, exb, frb};
            end
        end
    endfunction

    // Apply one word, check latency, packed value, hold stability and release.
    task automatic run_word(input logic [36:0] w, input logic [31:0] er, input logic eo,
                            input int el, input int hold);
        int n;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_word  = w;
        @(posedge clk);
        #1;
        // Keep presenting junk: it must be ignored while busy
        in_word = 37'({$urandom(), $urandom()});
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid === 1'b1) break;
            if (in_ready !== 1'b0) chk("in_ready_busy", 64'(in_ready), 64'd0);
        end
        chk("latency", 64'(n), 64'(el));
        chk("result", 64'(result), 64'(er));
        chk("ovf", 64'(ovf), 64'(eo));
        chk("in_ready_hold", 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", 64'(result), 64'(er));
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic        o;
        int          k;
        logic [36:0] w;
        logic [27:0] mm;
        logic [7:0]  ee;
        int          pos;
        int          sel;

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_word({1'b0, 8'h7F, 28'h4000000}, 32'h3F800000, 1'b0, 2, 5);
        run_word({1'b0, 8'h7F, 28'h8000000}, 32'h40000000, 1'b0, 2, 0);
        run_word({1'b0, 8'h82, 28'h0800000}, 32'h3F800000, 1'b0, 5, 1);
        run_word({1'b0, 8'h7F, 28'h4000004}, 32'h3F800000, 1'b0, 2, 0);
`ifdef FPADD_ROUND_EN
        run_word({1'b0, 8'h7F, 28'h400000C}, 32'h3F800002, 1'b0, 2, 0);
        run_word({1'b0, 8'h01, 28'h3FFFFFC}, 32'h00800000, 1'b0, 2, 0);
`else
        run_word({1'b0, 8'h7F, 28'h400000C}, 32'h3F800001, 1'b0, 2, 0);
        run_word({1'b0, 8'h01, 28'h3FFFFFC}, 32'h007FFFFF, 1'b0, 2, 0);
`endif
        run_word({1'b0, 8'hFE, 28'h8000000}, 32'h7F800000, 1'b1, 2, 0);
        run_word({1'b0, 8'hFF, 28'h8000000}, 32'h7F800000, 1'b1, 2, 0);
        run_word({1'b1, 8'h40, 28'h0000000}, 32'h80000000, 1'b0, 2, 0);
        run_word({1'b0, 8'h02, 28'h0000008}, 32'h00000002, 1'b0, 3, 0);

        // Reset during NORM aborts the word
        in_valid = 1'b1;
        in_word  = {1'b0, 8'h82, 28'h0800000};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_valid", 64'(out_valid), 64'd0);
        end
        run_word({1'b0, 8'h82, 28'h0800000}, 32'h3F800000, 1'b0, 5, 0);

        // Random words against the reference model
        for (int t = 0; t < 40; t++) begin
            pos = $urandom_range(0, 28);
            if (pos == 28) mm = 28'd0;
            else mm = 28'(($urandom() & ((32'd1 << pos) - 32'd1)) | (32'd1 << pos));
            sel = $urandom_range(0, 5);
            case (sel)
                0: ee = 8'h00;
                1: ee = 8'h01;
                2: ee = 8'h02;
                3: ee = 8'hFE;
                4: ee = 8'hFF;
                default: ee = 8'($urandom());
            endcase
            w = {1'($urandom()), ee, mm};
            model(w, r, o, k);
            run_word(w, r, o, 2 + k, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/norm_pack.md
NORM_PACK -- requirements
Module: norm_pack

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  the upstream sum word is valid.
REQ-005 in_ready  output  1  the block can accept a word; high only in IDLE.
REQ-006 in_word  input  37  [36] sign, [35:28] exponent E, [27:0] mantissa M.
REQ-007 Mantissa layout SHALL be: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-008 out_valid  output  1  result holds a packed value.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 result  output  32  IEEE-754 single: sign, 8-bit exponent, 23-bit fraction.
REQ-011 ovf  output  1  the result saturated to infinity; valid with out_valid.

Function
REQ-012 FSM states SHALL be IDLE, NORM, ROUND and HOLD.
REQ-013 IDLE SHALL work as follows: on in_valid&in_ready at an edge, register the sign, E as 9-bit, and M, then go to NORM.
REQ-014 At each NORM edge, the first matching case below SHALL apply.
- M[27]=1: shift M right by 1 with the sticky OR of the shifted-out bit into M[0], set E+1, go to ROUND.
- M=0: go to ROUND and flag zero.
- M[26]=1: go to ROUND.
- E<=1: go to ROUND and flag denormal.
- Otherwise: shift M left by 1 with a zero fill, set E-1, stay in NORM.
REQ-015 Left shifts SHALL be 1 bit per cycle, with at most 26 per word.
REQ-016 The ROUND edge SHALL register result and ovf, then go to HOLD, where out_valid=1.
REQ-017 Latency SHALL be as follows: out_valid rises after the (2+k)th edge following acceptance, where k is the left-shift count.
- A carry or already-normalized input gives a latency of 2.
REQ-018 HOLD SHALL work as follows: result, ovf and out_valid stay stable while out_ready=0; when out_ready=1 at an edge, go to IDLE.
- out_valid drops and in_ready rises after that edge; there is no same-cycle re-accept.
REQ-019 Zero handling SHALL be: result = {sign, 31'b0}, ovf=0.
REQ-020 Denormal handling SHALL be: exponent field 0, fraction from M[25:3] after rounding.
- If rounding carries into bit 26, the exponent field becomes 1.
REQ-021 If the final E>=255, then result = {sign, 8'hFF, 23'b0} and ovf=1.
- This includes an input E=255 with a carry, and a rounding carry that produces E=255.
REQ-022 A rounding carry out of the fraction SHALL set the fraction to 0 and E+1.
REQ-023 in_valid while not in IDLE SHALL be ignored; the word is not lost because in_ready=0.

Reset
REQ-024 While rst_n=0, the block SHALL force: state=IDLE, in_ready=1, out_valid=0, result=0, ovf=0, and clear the internal registers.
REQ-025 Reset asserted mid-operation (NORM, ROUND or HOLD) SHALL abort the word with no output, and the block resumes from IDLE.

Configuration
REQ-026 The macro SHALL be FPADD_ROUND_EN.
REQ-027 When FPADD_ROUND_EN is defined, rounding SHALL be round-to-nearest-even: increment when G & (R | S | M[3]).
REQ-028 When FPADD_ROUND_EN is undefined, the block SHALL truncate: G, R and S are discarded and rounding carries never occur.
- Latency and the FSM are unchanged.

Verification
REQ-029 Normalized input: in_word={0, 8'h7F, 28'h4000000} -> result=32'h3F800000, ovf=0, out_valid after the 2nd edge.
REQ-030 Carry input: {0, 8'h7F, 28'h8000000} -> 32'h40000000 with latency 2.
- Left shift: {0, 8'h82, 28'h0800000} -> 32'h3F800000 with latency 5 (k=3).
REQ-031 Rounding, tie case: {0, 8'h7F, 28'h4000004} -> 32'h3F800000.
- Rounding, odd LSB: {0, 8'h7F, 28'h400000C} -> 32'h3F800002 with FPADD_ROUND_EN, 32'h3F800001 without it.
REQ-032 Overflow: {0, 8'hFE, 28'h8000000} -> 32'h7F800000, ovf=1.
- Zero: {1, 8'h40, 28'h0} -> 32'h80000000.
- Denormal: {0, 8'h02, 28'h0000008} -> exponent field 0 after 1 shift.
REQ-033 Backpressure/reset: hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout.
- Pulse rst_n low during NORM -> out_valid stays 0 and the next word processes correctly.
